uart_tx: RTL

- Transmit path of the UART peripheral.
- Accepts CSR writes at the FIFO word/byte addresses and buffers bytes in a FifoQueueSize-deep byte FIFO.
- Serialises each byte onto the tx pin as 8N1 at CoreFreq/UartBaudRate.
- Sits between the core's CSR write port and the board pin.

---
 rtl/uart_tx_pkg.sv | 22 ++
 rtl/uart_tx_if.sv | 12 +
 rtl/uart_tx_fifo.sv | 48 ++++
 rtl/uart_tx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and defaults for the UART transmit path.
package uart_tx_pkg;

    localparam int FifoQueueSize = 256;
    localparam int UartCmpVal    = 173;

    typedef logic [11:0]                        CsrAddrT;
    typedef logic [$clog2(FifoQueueSize)-1:0]   FifoPtrT;
    typedef logic [$clog2(FifoQueueSize):0]     UartCountT;

    localparam CsrAddrT FifoWordCsrAddr = 12'h050;
    localparam CsrAddrT FifoByteCsrAddr = 12'h051;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } UartTxStateT;

endpackage

// File: rtl/uart_tx_if.sv
// CSR write port feeding the UART transmit FIFO.
interface uart_tx_if;
    import uart_tx_pkg::*;

    logic        csr_we;
    CsrAddrT     csr_addr;
    logic [31:0] csr_wdata;

    modport master (output csr_we, csr_addr, csr_wdata);
    modport slave  (input  csr_we, csr_addr, csr_wdata);

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter: 0, 1 or 4 bytes pushed per cycle, one byte popped.
module uart_tx_fifo import uart_tx_pkg::*; #(
    parameter int QueueSize = FifoQueueSize
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [2:0]                  push_len,
    input  logic [31:0]                 push_data,
    input  logic                        pop,
    output logic [7:0]                  head,
    output logic [$clog2(QueueSize):0]  count
);

    localparam int PtrW = $clog2(QueueSize);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [PtrW:0]   cnt_t;

    logic [7:0] mem [QueueSize];
    ptr_t       rd_ptr;
    ptr_t       wr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + ptr_t'(push_len);
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            count <= count + cnt_t'(push_len) - cnt_t'(pop);
        end
    end

    // Byte lanes land in consecutive slots; the pointer arithmetic wraps naturally.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!reset && (3'(i) < push_len)) begin
                mem[wr_ptr + ptr_t'(i)] <= push_data[8*i +: 8];
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: CSR-fed byte FIFO serialised as 8N1 (8E1 when UART_TX_PARITY_EN is defined).
//
// state  | meaning
// IDLE   | line high; pops the FIFO head as soon as one is available
// START  | start bit (low) for CmpVal cycles
// DATA   | eight data bits, LSB first, CmpVal cycles each
// PARITY | even parity bit (UART_TX_PARITY_EN builds only)
// STOP   | stop bit (high) for CmpVal cycles
module uart_tx import uart_tx_pkg::*; #(
    parameter int      QueueSize = FifoQueueSize,
    parameter int      CmpVal    = UartCmpVal,
    parameter CsrAddrT WordAddr  = FifoWordCsrAddr,
    parameter CsrAddrT ByteAddr  = FifoByteCsrAddr
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_tx_if.slave                    csr,
    output logic                        tx,
    output logic [$clog2(QueueSize):0]  fifo_count,
    output logic                        busy,
    output logic                        overflow
);

    localparam int CntW  = $clog2(QueueSize) + 1;
    localparam int BaudW = $clog2(CmpVal);

    typedef logic [CntW-1:0]  cnt_t;
    typedef logic [BaudW-1:0] baud_t;

    localparam cnt_t  WordLimit = cnt_t'(QueueSize - 4);
    localparam cnt_t  ByteLimit = cnt_t'(QueueSize - 1);
    localparam baud_t BaudLast  = baud_t'(CmpVal - 1);

    logic        word_wr;
    logic        byte_wr;
    logic        word_ok;
    logic        byte_ok;
    logic [2:0]  push_len;
    logic        pop;
    logic [7:0]  head;

    UartTxStateT state;
    UartTxStateT state_nxt;
    baud_t       baud;
    baud_t       baud_nxt;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_nxt;
    logic [7:0]  shift;
    logic [7:0]  shift_nxt;
    logic        tx_nxt;
    logic        baud_last;

    // Space is judged on the count before this cycle's pop; a concurrent pop earns no credit.
    assign word_wr = csr.csr_we && (csr.csr_addr == WordAddr);
    assign byte_wr = csr.csr_we && (csr.csr_addr == ByteAddr);
    assign word_ok = (fifo_count <= WordLimit);
    assign byte_ok = (fifo_count <= ByteLimit);

    always_comb begin
        push_len = '0;
        if (word_wr && word_ok) begin
            push_len = 3'd4;
        end else if (byte_wr && byte_ok) begin
            push_len = 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if ((word_wr && !word_ok) || (byte_wr && !byte_ok)) begin
            overflow <= 1'b1;
        end
    end

    uart_tx_fifo #(
        .QueueSize (QueueSize)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_len  (push_len),
        .push_data (csr.csr_wdata),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

`ifdef UART_TX_PARITY_EN
    logic parity;

    always_ff @(posedge clk) begin
        if (reset) begin
            parity <= 1'b0;
        end else if (pop) begin
            parity <= ^head;
        end
    end
`endif

    assign baud_last = (baud == BaudLast);

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud + baud_t'(1);
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        pop       = 1'b0;
        tx_nxt    = 1'b1;

        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (fifo_count != '0) begin
                    pop       = 1'b1;
                    shift_nxt = head;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    shift_nxt = {1'b0, shift[7:1]};
                    bit_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                baud_nxt  = '0;
                state_nxt = IDLE;
            end
        endcase

        // tx is registered from the next state so the pin never glitches.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_nxt = parity;
`endif
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nxt;
            baud    <= baud_nxt;
            bit_idx <= bit_nxt;
            shift   <= shift_nxt;
            tx      <= tx_nxt;
        end
    end

    assign busy = (state != IDLE) || (fifo_count != '0);

endmodule
